// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Word accesses with byte enables on the core side; whole 128-bit lines on the bus.
module data_cache #(
    parameter int unsigned BUS_ADDRESS_WIDTH    = 20,
    parameter int unsigned BUS_DATA_WIDTH_SHIFT = 4,
    parameter int unsigned INDEX_WIDTH          = 6
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            en_i,
    input  logic [31:2]                                     addr_i,
    input  logic [31:0]                                     data_i,
    input  logic [3:0]                                      write_en_i,
    output logic [31:0]                                     data_o,
    output logic                                            blocking_n_o,
    output logic                                            flushing_n_o,
    output logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_o,
    output logic [127:0]                                    bus_data_o,
    output logic                                            bus_we_o,
    output logic                                            bus_valid_o,
    input  logic [127:0]                                    bus_data_i,
    input  logic                                            bus_valid_i
);

    localparam int unsigned TAG_WIDTH = BUS_ADDRESS_WIDTH - INDEX_WIDTH - 4;
    localparam int unsigned NUM_LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_LINES];
    logic [127:0]           line_q [NUM_LINES];
    logic [TAG_WIDTH-1:0]   miss_tag_q;
    logic [INDEX_WIDTH-1:0] miss_index_q;

    logic [1:0]             offset;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   idle;
    logic                   hit;
    logic                   miss;
    logic                   store_hit;
    logic [31:0]            cur_word;
    logic [31:0]            merged_word;
    logic                   unused_addr_bits;

    assign offset = addr_i[3:2];
    assign index  = addr_i[INDEX_WIDTH+3:4];
    assign tag    = addr_i[BUS_ADDRESS_WIDTH-1:INDEX_WIDTH+4];

    // Address bits above the decoded range are deliberately ignored.
    assign unused_addr_bits = ^addr_i[31:BUS_ADDRESS_WIDTH];

    assign idle      = (state_q == StIdle);
    assign hit       = en_i & valid_q[index] & (tag_q[index] == tag);
    assign miss      = idle & en_i & ~hit;
    assign store_hit = idle & hit & (|write_en_i);
    assign cur_word  = line_q[index][{offset, 5'd0} +: 32];

    // Load data and stall: both purely combinational so hits cost no wait states.
    always_comb begin
        data_o       = '0;
        blocking_n_o = ~((en_i & ~hit) | ~idle);
        if (hit) begin
            data_o = cur_word;
        end
    end

    // Byte-merge the store data into the currently selected word.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (write_en_i[b]) begin
                merged_word[8*b +: 8] = data_i[8*b +: 8];
            end
        end
    end

    // Tag and data arrays: refill has priority; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StRefill && bus_valid_i) begin
                line_q[miss_index_q] <= bus_data_i;
                tag_q[miss_index_q]  <= miss_tag_q;
            end else if (store_hit) begin
                line_q[index][{offset, 5'd0} +: 32] <= merged_word;
            end
        end
    end

    // Miss FSM with registered bus outputs and per-line valid/dirty bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            bus_valid_o  <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            flushing_n_o <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (store_hit) begin
                        dirty_q[index] <= 1'b1;
                    end
                    if (miss) begin
                        miss_tag_q   <= tag;
                        miss_index_q <= index;
                        bus_valid_o  <= 1'b1;
                        if (valid_q[index] && dirty_q[index]) begin
                            state_q      <= StWriteback;
                            bus_we_o     <= 1'b1;
                            bus_addr_o   <= {tag_q[index], index};
                            bus_data_o   <= line_q[index];
                            flushing_n_o <= 1'b0;
                        end else begin
                            state_q    <= StRefill;
                            bus_we_o   <= 1'b0;
                            bus_addr_o <= {tag, index};
                            bus_data_o <= '0;
                        end
                    end
                end
                StWriteback: begin
                    if (bus_valid_i) begin
                        // Request stays up; it now names the line being fetched.
                        dirty_q[miss_index_q] <= 1'b0;
                        state_q               <= StRefill;
                        bus_we_o              <= 1'b0;
                        bus_addr_o            <= {miss_tag_q, miss_index_q};
                        bus_data_o            <= '0;
                        flushing_n_o          <= 1'b1;
                    end
                end
                StRefill: begin
                    if (bus_valid_i) begin
                        valid_q[miss_index_q] <= 1'b1;
                        dirty_q[miss_index_q] <= 1'b0;
                        state_q               <= StIdle;
                        bus_valid_o           <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed miss/write-back/reset sequences,
// then a vector table run against a word-level memory model with a load scoreboard.
module tb_data_cache;

    logic         clk;
    logic         rst;
    logic         en;
    logic [31:2]  addr;
    logic [31:0]  wdata;
    logic [3:0]   write_en;
    logic [31:0]  rdata;
    logic         blocking_n;
    logic         flushing_n;
    logic [19:4]  bus_addr;
    logic [127:0] bus_wdata;
    logic         bus_we;
    logic         bus_valid;
    logic [127:0] bus_rdata;
    logic         bus_valid_in;

    int checks = 0;
    int errors = 0;

    logic [31:0]  shadow [logic [17:0]];
    logic [127:0] mem    [logic [15:0]];
    logic [31:0]  exp_q  [$];

    typedef struct {
        logic [31:2] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          exp_miss;
        bit          exp_wb;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_M = 128'h44444444_33333333_2222CC22_11111111;
    localparam logic [127:0] LINE_D = 128'h88888888_77777777_66666666_55555555;

    data_cache dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .addr_i       (addr),
        .data_i       (wdata),
        .write_en_i   (write_en),
        .data_o       (rdata),
        .blocking_n_o (blocking_n),
        .flushing_n_o (flushing_n),
        .bus_addr_o   (bus_addr),
        .bus_data_o   (bus_wdata),
        .bus_we_o     (bus_we),
        .bus_valid_o  (bus_valid),
        .bus_data_i   (bus_rdata),
        .bus_valid_i  (bus_valid_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:2] mk(input logic [9:0] t, input logic [5:0] i,
                                       input logic [1:0] o);
        return {12'd0, t, i, o};
    endfunction

    function automatic logic [31:0] init_word(input logic [17:0] w);
        return {14'h1357, w};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:2] a);
        if (shadow.exists(a[19:2])) return shadow[a[19:2]];
        return init_word(a[19:2]);
    endfunction

    function automatic void model_write(input logic [31:2] a, input logic [3:0] we,
                                        input logic [31:0] d);
        logic [31:0] w;
        w = model_read(a);
        for (int b = 0; b < 4; b++) begin
            if (we[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        shadow[a[19:2]] = w;
    endfunction

    // Architectural contents of a line as the core should see it.
    function automatic logic [127:0] model_line(input logic [15:0] l);
        logic [127:0] r;
        for (int n = 0; n < 4; n++) r[32*n +: 32] = model_read({12'd0, l, 2'(n)});
        return r;
    endfunction

    // Backing-store contents of a line as the bus returns it.
    function automatic logic [127:0] mem_line(input logic [15:0] l);
        logic [127:0] r;
        if (mem.exists(l)) return mem[l];
        for (int n = 0; n < 4; n++) r[32*n +: 32] = init_word({l, 2'(n)});
        return r;
    endfunction

    // Drive one access, serve the bus until the core is released, then score it.
    task automatic do_access(input int id, input vec_t v);
        int          cyc;
        int          age;
        int          nwb;
        int          nrd;
        logic [15:0] held_addr;
        logic        held_we;
        logic [31:0] exp_word;
        en       = 1'b1;
        addr     = v.addr;
        write_en = v.we;
        wdata    = v.wdata;
        if (v.we == 4'd0) exp_q.push_back(model_read(v.addr));
        #1;
        check($sformatf("vec%0d stall", id), blocking_n, 1'(!v.exp_miss));
        if (!v.exp_miss) check($sformatf("vec%0d hit no bus", id), bus_valid, 0);
        cyc       = 0;
        age       = 0;
        nwb       = 0;
        nrd       = 0;
        held_addr = '0;
        held_we   = 1'b0;
        while (!blocking_n && cyc < 40) begin
            if (bus_valid) begin
                if (age == 0) begin
                    held_addr = bus_addr;
                    held_we   = bus_we;
                    age       = 1;
                end else begin
                    check($sformatf("vec%0d bus addr stable", id), bus_addr, held_addr);
                    check($sformatf("vec%0d bus we stable", id), bus_we, held_we);
                    if (bus_we) begin
                        nwb++;
                        check($sformatf("vec%0d wb data", id), bus_wdata, model_line(bus_addr));
                        check($sformatf("vec%0d flushing", id), flushing_n, 0);
                        mem[bus_addr] = bus_wdata;
                    end else begin
                        nrd++;
                        check($sformatf("vec%0d refill addr", id), bus_addr, v.addr[19:4]);
                        bus_rdata = mem_line(bus_addr);
                    end
                    bus_valid_in = 1'b1;
                    age          = 0;
                end
            end
            tick();
            bus_valid_in = 1'b0;
            cyc++;
        end
        check($sformatf("vec%0d released", id), blocking_n, 1);
        check($sformatf("vec%0d writebacks", id), nwb, v.exp_wb ? 1 : 0);
        check($sformatf("vec%0d refills", id), nrd, v.exp_miss ? 1 : 0);
        check($sformatf("vec%0d bus idle after", id), bus_valid, 0);
        if (v.we == 4'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vec%0d scoreboard: got empty queue, expected an entry", id);
            end else begin
                exp_word = exp_q.pop_front();
                check($sformatf("vec%0d load data", id), rdata, exp_word);
            end
        end else begin
            model_write(v.addr, v.we, v.wdata);
        end
        tick();
        en       = 1'b0;
        write_en = 4'd0;
    endtask

    initial begin
        logic [31:2] hi;
        hi = 30'h2000_0000;
        vecs[0]  = '{mk(10'd1, 6'd1, 2'd0), 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{mk(10'd1, 6'd1, 2'd3), 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{mk(10'd1, 6'd1, 2'd2), 4'hF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{mk(10'd1, 6'd1, 2'd2), 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{mk(10'd2, 6'd2, 2'd1), 4'h9, 32'h12345678, 1'b1, 1'b0};
        vecs[5]  = '{mk(10'd2, 6'd2, 2'd1), 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{mk(10'd3, 6'd1, 2'd0), 4'h0, 32'h0, 1'b1, 1'b1};
        vecs[7]  = '{mk(10'd1, 6'd1, 2'd2), 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{mk(10'd4, 6'd3, 2'd0), 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{mk(10'd4, 6'd3, 2'd1), 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{mk(10'd4, 6'd3, 2'd0), 4'h4, 32'h00AB0000, 1'b0, 1'b0};
        vecs[11] = '{mk(10'd5, 6'd3, 2'd3), 4'h0, 32'h0, 1'b1, 1'b1};
        vecs[12] = '{mk(10'd4, 6'd3, 2'd0), 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[13] = '{mk(10'd4, 6'd3, 2'd0) | hi, 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[14] = '{mk(10'd4, 6'd3, 2'd1) | hi, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[15] = '{mk(10'd5, 6'd3, 2'd3), 4'h0, 32'h0, 1'b1, 1'b1};
        vecs[16] = '{mk(10'h3FF, 6'd63, 2'd3), 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[17] = '{mk(10'h3FF, 6'd63, 2'd0), 4'h1, 32'h000000EE, 1'b0, 1'b0};
        vecs[18] = '{mk(10'd0, 6'd63, 2'd0), 4'h0, 32'h0, 1'b1, 1'b1};
        vecs[19] = '{mk(10'h3FF, 6'd63, 2'd0), 4'h0, 32'h0, 1'b1, 1'b0};

        rst          = 1'b1;
        en           = 1'b0;
        addr         = '0;
        wdata        = '0;
        write_en     = '0;
        bus_rdata    = '0;
        bus_valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset blocking_n", blocking_n, 1);
        check("reset bus_valid", bus_valid, 0);
        check("reset bus_we", bus_we, 0);
        check("reset flushing_n", flushing_n, 1);
        check("reset data_o", rdata, 0);

        // First miss: clean refill of line 0x40.
        en   = 1'b1;
        addr = 30'h100;
        #1;
        check("miss0 stall at once", blocking_n, 0);
        tick();
        check("miss0 bus_valid", bus_valid, 1);
        check("miss0 bus_we", bus_we, 0);
        check("miss0 bus_addr", bus_addr, 16'h40);
        bus_rdata    = LINE_A;
        bus_valid_in = 1'b1;
        tick();
        bus_valid_in = 1'b0;
        check("miss0 done data", rdata, 32'h11111111);
        check("miss0 done blocking_n", blocking_n, 1);
        check("miss0 bus dropped", bus_valid, 0);

        // Hit on another word of the same line.
        addr = 30'h103;
        #1;
        check("hit word3 data", rdata, 32'h44444444);
        check("hit word3 blocking_n", blocking_n, 1);
        tick();
        check("hit word3 no bus", bus_valid, 0);

        // Single-byte store hit, then read back.
        addr     = 30'h101;
        write_en = 4'b0010;
        wdata    = 32'hAABBCCDD;
        #1;
        check("store hit no stall", blocking_n, 1);
        tick();
        write_en = 4'b0000;
        #1;
        check("store merged", rdata, 32'h2222CC22);

        // Conflict miss on the dirty line: write-back then refill.
        addr = 30'h500;
        #1;
        check("dirty miss stall", blocking_n, 0);
        tick();
        check("wb bus_valid", bus_valid, 1);
        check("wb bus_we", bus_we, 1);
        check("wb flushing_n", flushing_n, 0);
        check("wb bus_addr", bus_addr, 16'h40);
        check("wb bus_data", bus_wdata, LINE_M);
        bus_valid_in = 1'b1;
        tick();
        bus_valid_in = 1'b0;
        check("refill after wb bus_valid", bus_valid, 1);
        check("refill after wb bus_we", bus_we, 0);
        check("refill after wb bus_addr", bus_addr, 16'h140);
        check("refill after wb flushing_n", flushing_n, 1);
        check("refill after wb bus_data", bus_wdata, 0);
        bus_rdata    = LINE_D;
        bus_valid_in = 1'b1;
        tick();
        bus_valid_in = 1'b0;
        check("refill after wb data", rdata, 32'h55555555);
        check("refill after wb blocking_n", blocking_n, 1);

        // Clean-victim miss: no write-back, request held for an extra cycle.
        addr = 30'h103;
        #1;
        check("clean miss stall", blocking_n, 0);
        tick();
        check("clean miss bus_valid", bus_valid, 1);
        check("clean miss bus_we", bus_we, 0);
        check("clean miss flushing_n", flushing_n, 1);
        check("clean miss bus_addr", bus_addr, 16'h40);
        tick();
        check("clean miss held bus_we", bus_we, 0);
        check("clean miss held bus_addr", bus_addr, 16'h40);
        bus_rdata    = LINE_M;
        bus_valid_in = 1'b1;
        tick();
        bus_valid_in = 1'b0;
        check("clean miss data", rdata, 32'h44444444);

        // Reset while refilling discards the line.
        addr = 30'h900;
        #1;
        check("rst miss stall", blocking_n, 0);
        tick();
        check("rst miss refill addr", bus_addr, 16'h240);
        check("rst miss bus_valid", bus_valid, 1);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        check("rst mid bus_valid", bus_valid, 0);
        check("rst mid blocking_n", blocking_n, 1);
        check("rst mid flushing_n", flushing_n, 1);
        en   = 1'b1;
        addr = 30'h900;
        #1;
        check("rst reaccess misses", blocking_n, 0);
        addr = 30'h103;
        #1;
        check("rst old line invalid", blocking_n, 0);
        en = 1'b0;
        #1;
        check("rst idle blocking_n", blocking_n, 1);
        tick();

        for (int i = 0; i < NV; i++) begin
            do_access(i, vecs[i]);
        end
        check("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
